// File: rtl/he_pkg.sv
// Shared types and width helpers for the streaming histogram equaliser.
package he_pkg;

   typedef enum logic [1:0] {
      IDLE,
      COLLECT,
      OUT
   } he_state_t;

   // Width of one slot count: must be able to hold FRAME_LEN itself.
   function automatic int he_cnt_w(input int frame_len);
      return $clog2(frame_len) + 1;
   endfunction

   // Width of the pixel index; clamped to 1 so a one-pixel frame still has a legal vector.
   function automatic int he_idx_w(input int frame_len);
      return (frame_len > 1) ? $clog2(frame_len) : 1;
   endfunction

endpackage

// File: rtl/he_scale.sv
// Maps a CDF count onto the output range: floor(cnt * (2^PIX_W - 1) / FRAME_LEN).
module he_scale
   import he_pkg::*;
#(
   parameter int PIX_W     = 8,
   parameter int FRAME_LEN = 1024
) (
   input  logic [he_cnt_w(FRAME_LEN)-1:0] cnt,
   output logic [PIX_W-1:0]               scaled
);

   localparam int CNT_W = he_cnt_w(FRAME_LEN);
   localparam int SHIFT = $clog2(FRAME_LEN);

   logic [CNT_W+PIX_W-1:0] wide;

   // cnt*(2^PIX_W-1) as a shift and subtract; FRAME_LEN is a power of two so the divide is a shift.
   always_comb begin
      wide   = {cnt, {PIX_W{1'b0}}} - {{PIX_W{1'b0}}, cnt};
      scaled = PIX_W'(wide >> SHIFT);
   end

endmodule

// File: rtl/he_stream_eq.sv
// Streaming histogram equaliser: tracks the first N_TRACK pixels of a frame, counts how many
// frame pixels are <= each, then streams the scaled counts out in capture order.
module he_stream_eq
   import he_pkg::*;
#(
   parameter int PIX_W     = 8,
   parameter int FRAME_LEN = 1024,
   parameter int N_TRACK   = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [PIX_W-1:0] in_image,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PIX_W-1:0] out_image
);

   localparam int CNT_W  = he_cnt_w(FRAME_LEN);
   localparam int IDX_W  = he_idx_w(FRAME_LEN);
   localparam int OIDX_W = (N_TRACK > 1) ? $clog2(N_TRACK) : 1;
   localparam logic [IDX_W-1:0]  LAST_PIX = IDX_W'(FRAME_LEN - 1);
   localparam logic [OIDX_W-1:0] LAST_OUT = OIDX_W'(N_TRACK - 1);

   he_state_t state, state_next;

   logic [IDX_W-1:0]  pix_cnt;
   logic [OIDX_W-1:0] out_idx;
   logic [PIX_W-1:0]  slot [N_TRACK];
   logic [CNT_W-1:0]  cnt  [N_TRACK];

   logic [N_TRACK-1:0] hit;
   logic [CNT_W-1:0]   rank;
   logic               accept;
   logic               last_pix;
   logic               xfer;
   logic               last_out;
   logic [CNT_W-1:0]   sel_cnt;
   logic [PIX_W-1:0]   scaled;

   assign in_ready  = (state != OUT);
   assign out_valid = (state == OUT);
   assign accept    = in_valid && in_ready;
   assign xfer      = out_valid && out_ready;
   assign last_pix  = (pix_cnt == LAST_PIX);
   assign last_out  = (out_idx == LAST_OUT);

   // Compare the incoming pixel with every slot already filled (index below pix_cnt):
   // hit marks slots whose count grows, rank is how many filled slots are <= the new pixel.
   always_comb begin
      hit  = '0;
      rank = '0;
      for (int k = 0; k < N_TRACK; k++) begin
         if (k < int'(pix_cnt)) begin
            if (in_image <= slot[k]) hit[k] = 1'b1;
            if (slot[k] <= in_image) rank = rank + CNT_W'(1);
         end
      end
   end

   // Next state: collect a full frame, then drain N_TRACK results.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (accept) state_next = last_pix ? OUT : COLLECT;
         COLLECT: if (accept && last_pix) state_next = OUT;
         OUT:     if (xfer && last_out) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Datapath: pixel index, slot capture and count updates, output index; cleared after the last transfer.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pix_cnt <= '0;
         out_idx <= '0;
         for (int k = 0; k < N_TRACK; k++) begin
            slot[k] <= '0;
            cnt[k]  <= '0;
         end
      end else begin
         if (accept) begin
            pix_cnt <= last_pix ? '0 : pix_cnt + IDX_W'(1);
            for (int k = 0; k < N_TRACK; k++) begin
               if (hit[k]) begin
                  cnt[k] <= cnt[k] + CNT_W'(1);
               end else if (k == int'(pix_cnt)) begin
                  slot[k] <= in_image;
                  cnt[k]  <= rank + CNT_W'(1);
               end
            end
         end
         if (xfer) begin
            if (last_out) begin
               out_idx <= '0;
               for (int k = 0; k < N_TRACK; k++) begin
                  slot[k] <= '0;
                  cnt[k]  <= '0;
               end
            end else begin
               out_idx <= out_idx + OIDX_W'(1);
            end
         end
      end
   end

   assign sel_cnt = cnt[out_idx];

   he_scale #(
      .PIX_W    (PIX_W),
      .FRAME_LEN(FRAME_LEN)
   ) u_scale (
      .cnt   (sel_cnt),
      .scaled(scaled)
   );

   assign out_image = out_valid ? scaled : '0;

endmodule

// File: tb/tb_he_stream_eq.sv
// Bench for he_stream_eq: default configuration plus a small 4-bit/16-pixel/4-slot instance.
module tb_he_stream_eq;

   localparam int PW  = 8;
   localparam int FL  = 1024;
   localparam int NT  = 8;
   localparam int SPW = 4;
   localparam int SFL = 16;
   localparam int SNT = 4;

   typedef int exp_t[NT];
   typedef int sexp_t[SNT];
   typedef int spix_t[SFL];
   typedef struct {
      spix_t pix;
      sexp_t exp;
   } small_vec_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
   logic [PW-1:0] in_image = '0;
   logic          in_ready, out_valid;
   logic [PW-1:0] out_image;

   logic           s_rst_n = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b1;
   logic [SPW-1:0] s_in_image = '0;
   logic           s_in_ready, s_out_valid;
   logic [SPW-1:0] s_out_image;

   he_stream_eq #(.PIX_W(PW), .FRAME_LEN(FL), .N_TRACK(NT)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_image(in_image),
      .out_valid(out_valid), .out_ready(out_ready), .out_image(out_image)
   );

   he_stream_eq #(.PIX_W(SPW), .FRAME_LEN(SFL), .N_TRACK(SNT)) dut_s (
      .clk(clk), .rst_n(s_rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_image(s_in_image),
      .out_valid(s_out_valid), .out_ready(s_out_ready), .out_image(s_out_image)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int frame_q[$];

   task automatic check_output(input string name, input int actual, input int expected);
      n_checks++;
      if (actual == expected) n_pass++;
      else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
   endtask

   // Reference: CDF of tracked pixel k over the whole frame, scaled with integer arithmetic.
   function automatic int model_val(input int k, input int pw, input int flen);
      int c = 0;
      foreach (frame_q[j]) if (frame_q[j] <= frame_q[k]) c++;
      return (c * ((1 << pw) - 1)) / flen;
   endfunction

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; s_rst_n = 1'b0; in_valid = 1'b0; s_in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; s_rst_n = 1'b1;
   endtask

   // Streams frame_q[0..n_pix-1] with random idle cycles; returns right after the accepting edge of the last pixel.
   task automatic apply_stimulus(input int n_pix, input int gap_pct, input string tag);
      int idx = 0, budget = 0, early_ov = 0, ready_err = 0;
      bit take;
      while (idx < n_pix && budget < 20000) begin
         @(negedge clk);
         if (out_valid) early_ov++;
         if (!in_ready) ready_err++;
         in_valid = ($urandom_range(99) >= gap_pct);
         in_image = PW'(frame_q[idx]);
         take = in_valid && in_ready;
         @(posedge clk);
         if (take) idx++;
         budget++;
      end
      check_output($sformatf("%s_send_done", tag), idx, n_pix);
      check_output($sformatf("%s_no_early_valid", tag), early_ov, 0);
      check_output($sformatf("%s_in_ready_collect", tag), ready_err, 0);
   endtask

   // Drains the outputs; mode 1 stalls with a 1,0,0 out_ready pattern and holds in_valid high.
   task automatic recv_frame(input int mode, input exp_t exp, input string tag);
      int got[$];
      int cyc = 0, stall_err = 0, ready_err = 0, held = 0;
      bit prev_stall = 1'b0;
      @(negedge clk);
      check_output($sformatf("%s_first_valid", tag), int'(out_valid), 1);
      while (got.size() < NT && cyc < 200) begin
         out_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 0);
         if (mode == 1) begin
            in_valid = 1'b1;
            in_image = 8'hAB;
         end else begin
            in_valid = 1'b0;
         end
         if (out_valid) begin
            if (in_ready) ready_err++;
            if (prev_stall && int'(out_image) != held) stall_err++;
            if (out_ready) got.push_back(int'(out_image));
         end else begin
            ready_err++;
         end
         prev_stall = out_valid && !out_ready;
         held = int'(out_image);
         cyc++;
         @(negedge clk);
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
      check_output($sformatf("%s_n_out", tag), got.size(), NT);
      for (int k = 0; k < NT; k++)
         check_output($sformatf("%s_out%0d", tag, k), (k < got.size()) ? got[k] : -1, exp[k]);
      check_output($sformatf("%s_stall_hold", tag), stall_err, 0);
      check_output($sformatf("%s_in_ready_out", tag), ready_err, 0);
      check_output($sformatf("%s_valid_low_after", tag), int'(out_valid), 0);
      check_output($sformatf("%s_idle_ready", tag), int'(in_ready), 1);
      if (mode == 0) check_output($sformatf("%s_xfer_cycles", tag), cyc, NT);
   endtask

   // Small instance: gapless frame, always-ready drain.
   task automatic run_small(input spix_t pix, input sexp_t exp, input string tag);
      int got[$];
      int n = 0;
      for (int i = 0; i < SFL; i++) begin
         @(negedge clk);
         s_in_valid = 1'b1;
         s_in_image = SPW'(pix[i]);
      end
      @(negedge clk);
      s_in_valid = 1'b0;
      s_out_ready = 1'b1;
      check_output($sformatf("%s_first_valid", tag), int'(s_out_valid), 1);
      while (s_out_valid && n < 10) begin
         got.push_back(int'(s_out_image));
         @(negedge clk);
         n++;
      end
      check_output($sformatf("%s_n_out", tag), got.size(), SNT);
      for (int k = 0; k < SNT; k++)
         check_output($sformatf("%s_out%0d", tag, k), (k < got.size()) ? got[k] : -1, exp[k]);
   endtask

   exp_t       e;
   small_vec_t tbl[5];
   spix_t      sp;
   sexp_t      se;

   initial begin
      for (int i = 0; i < SFL; i++) begin
         tbl[0].pix[i] = (i == 0) ? 15 : 0;
         tbl[1].pix[i] = 0;
         tbl[2].pix[i] = i;
         tbl[3].pix[i] = 15;
         tbl[4].pix[i] = 15 - i;
      end
      tbl[0].exp = '{15, 14, 14, 14};
      tbl[1].exp = '{15, 15, 15, 15};
      tbl[2].exp = '{0, 1, 2, 3};
      tbl[3].exp = '{15, 15, 15, 15};
      tbl[4].exp = '{15, 14, 13, 12};

      do_reset();
      check_output("reset_out_valid", int'(out_valid), 0);
      check_output("reset_out_image", int'(out_image), 0);
      check_output("reset_in_ready", int'(in_ready), 1);
      check_output("reset_s_out_valid", int'(s_out_valid), 0);

      // Flat frame: every count is FRAME_LEN.
      frame_q.delete();
      for (int i = 0; i < FL; i++) frame_q.push_back(100);
      for (int k = 0; k < NT; k++) e[k] = 255;
      apply_stimulus(FL, 0, "flat");
      recv_frame(0, e, "flat");

      // Ramp 0..255 four times, gapless then with idle cycles.
      frame_q.delete();
      for (int i = 0; i < FL; i++) frame_q.push_back(i % 256);
      for (int k = 0; k < NT; k++) e[k] = k;
      apply_stimulus(FL, 0, "ramp");
      recv_frame(0, e, "ramp");
      apply_stimulus(FL, 30, "ramp_gap");
      recv_frame(0, e, "ramp_gap");

      // Random frame drained under back-pressure with in_valid held during output.
      frame_q.delete();
      for (int i = 0; i < FL; i++) frame_q.push_back(int'($urandom_range(255)));
      for (int k = 0; k < NT; k++) e[k] = model_val(k, PW, FL);
      apply_stimulus(FL, 20, "rand_bp");
      recv_frame(1, e, "rand_bp");

      // Ramp again: any pixel swallowed during output would misalign this frame.
      frame_q.delete();
      for (int i = 0; i < FL; i++) frame_q.push_back(i % 256);
      for (int k = 0; k < NT; k++) e[k] = k;
      apply_stimulus(FL, 10, "after_bp");
      recv_frame(0, e, "after_bp");

      // Abort a frame with reset, then an all-zero frame.
      frame_q.delete();
      for (int i = 0; i < 500; i++) frame_q.push_back(int'($urandom_range(255)));
      apply_stimulus(500, 0, "abort");
      do_reset();
      check_output("abort_reset_in_ready", int'(in_ready), 1);
      check_output("abort_reset_out_valid", int'(out_valid), 0);
      frame_q.delete();
      for (int i = 0; i < FL; i++) frame_q.push_back(0);
      for (int k = 0; k < NT; k++) e[k] = 255;
      apply_stimulus(FL, 0, "zero");
      recv_frame(0, e, "zero");

      // One more random frame with gaps and stalls.
      frame_q.delete();
      for (int i = 0; i < FL; i++) frame_q.push_back(int'($urandom_range(255)));
      for (int k = 0; k < NT; k++) e[k] = model_val(k, PW, FL);
      apply_stimulus(FL, 35, "rand2");
      recv_frame(1, e, "rand2");

      // Small instance: hand-derived table.
      for (int t = 0; t < 5; t++) run_small(tbl[t].pix, tbl[t].exp, $sformatf("small_tbl%0d", t));

      // Small instance: random frames against the model.
      for (int r = 0; r < 10; r++) begin
         frame_q.delete();
         for (int i = 0; i < SFL; i++) begin
            sp[i] = int'($urandom_range(15));
            frame_q.push_back(sp[i]);
         end
         for (int k = 0; k < SNT; k++) se[k] = model_val(k, SPW, SFL);
         run_small(sp, se, $sformatf("small_rand%0d", r));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/he_stream_eq.md
Name: he_stream_eq

Overview:
- Parametrised histogram-equalisation engine for streamed grayscale frames.
- Captures the first N_TRACK pixels of a FRAME_LEN-pixel frame and counts, for each captured pixel, how many frame pixels are less than or equal to it (its CDF value).
- After the frame, emits the N_TRACK equalised values in capture order through a valid/ready output handshake.
- Successor to the fixed 8-bit / 1024-pixel / 8-output equaliser: adds generic widths and depths, input gaps, input back-pressure and output back-pressure.

Parameters:
- PIX_W, 8, pixel bit width.
- FRAME_LEN, 1024, pixels per frame. Must be a power of two and ≥ N_TRACK.
- N_TRACK, 8, number of leading pixels equalised and output. Must be ≥ 1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  in_image is valid this cycle.
- in_ready  out  1  block accepts a pixel this cycle.
- in_image  in  PIX_W  input pixel.
- out_valid  out  1  out_image is valid.
- out_ready  in  1  downstream accepts out_image.
- out_image  out  PIX_W  equalised pixel.

Behaviour:
- Reset and clocking:
  - One clock. Reset is synchronous and active-low: sampled on the clk edge, applied regardless of other inputs, and aborts any frame in progress.
  - After reset: state = IDLE, out_valid = 0, out_image = 0, in_ready = 1, all counters and slots cleared.
- Acceptance and counter widths:
  - A pixel is accepted on a cycle with in_valid && in_ready.
  - Gaps (in_valid = 0) are allowed anywhere in a frame and do not advance any counter.
  - Pixel index counter pix_cnt is clog2(FRAME_LEN) bits and counts accepted pixels.
  - Each slot count cnt[k] is clog2(FRAME_LEN)+1 bits, so it can reach FRAME_LEN.
- States:
  - IDLE: in_ready = 1. The first accepted pixel is stored in slot 0, cnt[0] is set to 1, pix_cnt is set to 1, and the state moves to COLLECT. If FRAME_LEN = 1, the state moves to OUT instead.
  - COLLECT: in_ready = 1. For accepted pixel p at index j:
    - every filled slot k < min(j, N_TRACK) with p ≤ slot[k] does cnt[k] += 1;
    - if j < N_TRACK, slot[j] = p and cnt[j] = 1 + (number of filled slots i < j with slot[i] ≤ p);
    - all updates occur in the same cycle.
    - When j = FRAME_LEN-1 is accepted, the state moves to OUT on the next edge, with the final counts included.
  - OUT: in_ready = 0 and out_valid = 1.
    - out_idx starts at 0 and out_image is presented for slot out_idx.
    - out_idx advances only on out_valid && out_ready.
    - Stall with out_ready = 0: out_image and out_valid hold stable.
    - Transfer of index N_TRACK-1: next state is IDLE, out_valid = 0, and slots and counts are cleared.
- Latency and throughput:
  - First out_valid is asserted the cycle after the last pixel is accepted.
  - With out_ready held at 1, out_valid stays high for exactly N_TRACK cycles.
  - IDLE is re-entered on the edge after the last transfer; a new frame can be accepted in the following cycle.
- Arithmetic:
  - out_image = floor(cnt * (2^PIX_W - 1) / FRAME_LEN), computed exactly as ((cnt << PIX_W) - cnt) >> log2(FRAME_LEN).
  - The intermediate is clog2(FRAME_LEN)+1+PIX_W bits.
  - Because cnt ≤ FRAME_LEN, the result always fits PIX_W bits; no saturation is needed.
  - Comparisons are unsigned and use ≤, so ties are counted.
- Boundaries:
  - Pixel value 0 and pixel value 2^PIX_W-1 need no special-casing.
  - A pixel at index j < N_TRACK is compared only against slots already filled.
  - in_valid asserted during OUT is ignored (not accepted); the upstream must hold the pixel.

Decomposition:
- he_pkg holds:
  - the state enum he_state_t {IDLE, COLLECT, OUT};
  - localparam helpers CNT_W = $clog2(FRAME_LEN)+1 and IDX_W = $clog2(FRAME_LEN).
- One sub-module, he_scale: purely combinational; takes cnt, returns the scaled PIX_W result; parametrised by PIX_W and FRAME_LEN.
- he_stream_eq instantiates he_scale once, muxed by out_idx.

Test Plan:
- Default parameters, 1024 pixels all = 100, out_ready = 1 -> eight outputs of 255, on the 8 consecutive cycles after the last input; in_ready = 0 throughout those cycles.
- Frame = ramp 0..255 repeated 4 times -> slots 0..7 hold values 0..7, counts 4,8,...,32, outputs 0,1,2,3,4,5,6,7.
- Same ramp frame with random in_valid gaps (about 30% idle) -> identical outputs; out_valid rises exactly one cycle after the 1024th accepted pixel.
- out_ready toggling 1,0,0,1,... during OUT -> out_image holds during stalls, exactly 8 transfers in capture order, then IDLE; in_valid asserted during OUT is not consumed.
- rst_n = 0 for one cycle after 500 pixels, then a fresh all-zero frame -> outputs all 255, with no residue from the aborted frame.
- PIX_W = 4, FRAME_LEN = 16, N_TRACK = 4, frame 15,0,0,...,0 -> counts 16,15,15,15, outputs 15,14,14,14.
